ray_column_scheduler: RTL and testbench

- Frame-level controller for the ray caster.
- On each frame request it snapshots the player pose and sweeps NUM_COLS screen columns. For each column it computes the ray angle, launches the horizontal and vertical wall-intersection finders together, and collects both results.
- It picks the nearer hit and hands one column record per ray to the column renderer over a valid/ready handshake.

---
 rtl/raycast_pkg.sv | 35 +++
 rtl/nearest_hit_select.sv | 68 ++++++
 rtl/ray_column_scheduler.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ray_column_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raycast_pkg.sv
// ============================================================================
//  Module   : raycast_pkg
//  Purpose  : Shared constants, state encoding and helpers for the ray caster
//             column scheduler and its nearest-hit selector.
//  Ports    : (package - no ports)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package raycast_pkg;

    localparam int          ANGLE_FULL = 360;
    localparam int          MAZE_MAX   = 4095;
    localparam logic [12:0] DIST_NONE  = 13'h1FFF;
    localparam logic        SIDE_HORIZ = 1'b0;
    localparam logic        SIDE_VERT  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_SELECT = 3'd3,
        S_OUTPUT = 3'd4,
        S_DONE   = 3'd5
    } ray_state_e;

    // Absolute difference of two maze coordinates; never exceeds MAZE_MAX.
    function automatic logic [11:0] abs_diff12(input logic [11:0] a,
                                               input logic [11:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nearest_hit_select.sv
// ============================================================================
//  Module   : nearest_hit_select
//  Purpose  : Combinational choice between the horizontal-grid and the
//             vertical-grid wall hits of one ray, by Manhattan distance.
//  Ports    : h_found_i/h_wall_x_i/h_wall_y_i  horizontal finder result
//             v_found_i/v_wall_x_i/v_wall_y_i  vertical finder result
//             ray_x_i/ray_y_i                  ray origin
//             dist_o   |dx|+|dy| of the chosen hit, DIST_NONE if none
//             hit_o    a wall was found
//             side_o   SIDE_HORIZ / SIDE_VERT of the chosen hit
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nearest_hit_select
    import raycast_pkg::*;
(
    input  logic        h_found_i,
    input  logic [11:0] h_wall_x_i,
    input  logic [11:0] h_wall_y_i,
    input  logic        v_found_i,
    input  logic [11:0] v_wall_x_i,
    input  logic [11:0] v_wall_y_i,
    input  logic [11:0] ray_x_i,
    input  logic [11:0] ray_y_i,
    output logic [12:0] dist_o,
    output logic        hit_o,
    output logic        side_o
);

    // Each term is at most 4095, so the 13-bit sum (max 8190) cannot
    // overflow and can never collide with DIST_NONE.
    logic [12:0] w_h_dist;
    logic [12:0] w_v_dist;

    assign w_h_dist = {1'b0, abs_diff12(h_wall_x_i, ray_x_i)}
                    + {1'b0, abs_diff12(h_wall_y_i, ray_y_i)};
    assign w_v_dist = {1'b0, abs_diff12(v_wall_x_i, ray_x_i)}
                    + {1'b0, abs_diff12(v_wall_y_i, ray_y_i)};

    always_comb begin
        dist_o = DIST_NONE;
        hit_o  = 1'b0;
        side_o = SIDE_HORIZ;
        if (h_found_i && v_found_i) begin
            hit_o = 1'b1;
            // Strict compare: a tie resolves to the horizontal hit.
            if (w_v_dist < w_h_dist) begin
                dist_o = w_v_dist;
                side_o = SIDE_VERT;
            end else begin
                dist_o = w_h_dist;
                side_o = SIDE_HORIZ;
            end
        end else if (h_found_i) begin
            hit_o  = 1'b1;
            dist_o = w_h_dist;
            side_o = SIDE_HORIZ;
        end else if (v_found_i) begin
            hit_o  = 1'b1;
            dist_o = w_v_dist;
            side_o = SIDE_VERT;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ray_column_scheduler.sv
// ============================================================================
//  Module   : ray_column_scheduler
//  Purpose  : Frame-level controller of the ray caster. Snapshots the player
//             pose, sweeps NUM_COLS columns, launches both wall finders per
//             ray, picks the nearer hit and streams one column record per
//             ray to the renderer over a valid/ready handshake.
//  Ports    : clock_i, reset_i            clock, synchronous active-high reset
//             frame_start_i               frame request (ignored while busy)
//             player_x_i/_y_i/_angle_i    player pose
//             ray_x_o/_y_o/_alpha_o       ray description to both finders
//             horiz_begin_o/vert_begin_o  finder start pulses
//             horiz_*_i / vert_*_i        finder end, found flag, wall x/y
//             col_valid_o/col_ready_i     column record handshake
//             col_index_o/_dist_o/_hit_o/_side_o  column record
//             busy_o, frame_done_o        frame status
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ray_column_scheduler
    import raycast_pkg::*;
#(
    parameter  int NUM_COLS       = 60,
    parameter  int HALF_FOV       = 30,
    parameter  int ANGLE_STEP     = 1,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int IDX_W          = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             frame_start_i,
    input  logic [11:0]      player_x_i,
    input  logic [11:0]      player_y_i,
    input  logic [11:0]      player_angle_i,
    output logic [11:0]      ray_x_o,
    output logic [11:0]      ray_y_o,
    output logic [11:0]      ray_alpha_o,
    output logic             horiz_begin_o,
    output logic             vert_begin_o,
    input  logic             horiz_end_i,
    input  logic             vert_end_i,
    input  logic             horiz_found_i,
    input  logic             vert_found_i,
    input  logic [11:0]      horiz_wall_x_i,
    input  logic [11:0]      horiz_wall_y_i,
    input  logic [11:0]      vert_wall_x_i,
    input  logic [11:0]      vert_wall_y_i,
    output logic             col_valid_o,
    input  logic             col_ready_i,
    output logic [IDX_W-1:0] col_index_o,
    output logic [12:0]      col_dist_o,
    output logic             col_hit_o,
    output logic             col_side_o,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam int               TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_COLS - 1);
    localparam logic [11:0]      STEP12   = 12'(ANGLE_STEP);
    localparam logic [11:0]      WRAP12   = 12'(ANGLE_FULL - ANGLE_STEP);
    localparam logic [12:0]      FOV13    = 13'(HALF_FOV);
    localparam logic [12:0]      FULL13   = 13'(ANGLE_FULL);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    ray_state_e       state_q;
    logic [11:0]      ray_x_q;
    logic [11:0]      ray_y_q;
    logic [11:0]      alpha_q;
    logic             begin_q;
    logic [IDX_W-1:0] col_index_q;
    logic [TO_W-1:0]  timeout_q;
    logic             h_done_q;
    logic             v_done_q;
    logic             h_found_q;
    logic             v_found_q;
    logic [11:0]      h_x_q;
    logic [11:0]      h_y_q;
    logic [11:0]      v_x_q;
    logic [11:0]      v_y_q;
    logic             col_valid_q;
    logic [12:0]      col_dist_q;
    logic             col_hit_q;
    logic             col_side_q;
    logic             busy_q;
    logic             frame_done_q;

    // ------------------------------------------------------------------
    // Next-value helpers
    // ------------------------------------------------------------------
    logic [12:0] alpha_sum_d;
    logic [11:0] alpha_start_d;
    logic [11:0] alpha_step_d;
    logic        h_take_d;
    logic        v_take_d;
    logic        h_done_d;
    logic        v_done_d;
    logic        wait_exit_d;

    always_comb begin
        // Player angle is 0..359, so one conditional subtract gives the mod.
        alpha_sum_d   = {1'b0, player_angle_i} + FOV13;
        alpha_start_d = (alpha_sum_d >= FULL13) ? 12'(alpha_sum_d - FULL13)
                                                : alpha_sum_d[11:0];
        alpha_step_d  = (alpha_q < STEP12) ? (alpha_q + WRAP12)
                                           : (alpha_q - STEP12);

        // Only the first end seen per finder and per ray is taken.
        h_take_d    = (state_q == S_WAIT) && horiz_end_i && !h_done_q;
        v_take_d    = (state_q == S_WAIT) && vert_end_i  && !v_done_q;
        h_done_d    = h_done_q | h_take_d;
        v_done_d    = v_done_q | v_take_d;
        wait_exit_d = (h_done_d && v_done_d) || (timeout_q == TO_LAST);
    end

    // ------------------------------------------------------------------
    // Nearest-hit selection from the captured finder results
    // ------------------------------------------------------------------
    logic [12:0] w_sel_dist;
    logic        w_sel_hit;
    logic        w_sel_side;

    nearest_hit_select u_select (
        .h_found_i  (h_found_q),
        .h_wall_x_i (h_x_q),
        .h_wall_y_i (h_y_q),
        .v_found_i  (v_found_q),
        .v_wall_x_i (v_x_q),
        .v_wall_y_i (v_y_q),
        .ray_x_i    (ray_x_q),
        .ray_y_i    (ray_y_q),
        .dist_o     (w_sel_dist),
        .hit_o      (w_sel_hit),
        .side_o     (w_sel_side)
    );

    // ------------------------------------------------------------------
    // Frame FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            ray_x_q      <= '0;
            ray_y_q      <= '0;
            alpha_q      <= '0;
            begin_q      <= 1'b0;
            col_index_q  <= '0;
            timeout_q    <= '0;
            h_done_q     <= 1'b0;
            v_done_q     <= 1'b0;
            h_found_q    <= 1'b0;
            v_found_q    <= 1'b0;
            h_x_q        <= '0;
            h_y_q        <= '0;
            v_x_q        <= '0;
            v_y_q        <= '0;
            col_valid_q  <= 1'b0;
            col_dist_q   <= DIST_NONE;
            col_hit_q    <= 1'b0;
            col_side_q   <= SIDE_HORIZ;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (frame_start_i) begin
                        ray_x_q     <= player_x_i;
                        ray_y_q     <= player_y_i;
                        alpha_q     <= alpha_start_d;
                        col_index_q <= '0;
                        begin_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    begin_q   <= 1'b0;
                    h_done_q  <= 1'b0;
                    v_done_q  <= 1'b0;
                    h_found_q <= 1'b0;
                    v_found_q <= 1'b0;
                    timeout_q <= '0;
                    state_q   <= S_WAIT;
                end

                S_WAIT: begin
                    if (h_take_d) begin
                        h_done_q  <= 1'b1;
                        h_found_q <= horiz_found_i;
                        h_x_q     <= horiz_wall_x_i;
                        h_y_q     <= horiz_wall_y_i;
                    end
                    if (v_take_d) begin
                        v_done_q  <= 1'b1;
                        v_found_q <= vert_found_i;
                        v_x_q     <= vert_wall_x_i;
                        v_y_q     <= vert_wall_y_i;
                    end
                    timeout_q <= timeout_q + 1'b1;
                    // On timeout a silent finder keeps found = 0, which was
                    // cleared at launch, so it simply counts as a miss.
                    if (wait_exit_d) begin
                        state_q <= S_SELECT;
                    end
                end

                S_SELECT: begin
                    col_dist_q  <= w_sel_dist;
                    col_hit_q   <= w_sel_hit;
                    col_side_q  <= w_sel_side;
                    col_valid_q <= 1'b1;
                    state_q     <= S_OUTPUT;
                end

                S_OUTPUT: begin
                    if (col_ready_i) begin
                        col_valid_q <= 1'b0;
                        if (col_index_q == IDX_LAST) begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            col_index_q <= col_index_q + 1'b1;
                            alpha_q     <= alpha_step_d;
                            begin_q     <= 1'b1;
                            state_q     <= S_LAUNCH;
                        end
                    end
                end

                S_DONE: begin
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end

                default: begin
                    begin_q      <= 1'b0;
                    col_valid_q  <= 1'b0;
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ray_x_o       = ray_x_q;
    assign ray_y_o       = ray_y_q;
    assign ray_alpha_o   = alpha_q;
    assign horiz_begin_o = begin_q;
    assign vert_begin_o  = begin_q;
    assign col_valid_o   = col_valid_q;
    assign col_index_o   = col_index_q;
    assign col_dist_o    = col_dist_q;
    assign col_hit_o     = col_hit_q;
    assign col_side_o    = col_side_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_ray_column_scheduler.sv
// ============================================================================
//  Module   : tb_ray_column_scheduler
//  Purpose  : Self-checking bench for ray_column_scheduler. Each frame is
//             described by per-column finder delays/results and renderer
//             stalls; a timeline of every column is derived arithmetically
//             and the DUT outputs are compared against it on every cycle.
//  Ports    : (none)
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ray_column_scheduler;

    localparam int NUM_COLS = 60;
    localparam int HALF_FOV = 30;
    localparam int STEP     = 1;
    localparam int TMO      = 256;

    logic        clock, reset, frame_start;
    logic [11:0] player_x, player_y, player_angle;
    logic [11:0] ray_x, ray_y, ray_alpha;
    logic        horiz_begin, vert_begin;
    logic        horiz_end, vert_end, horiz_found, vert_found;
    logic [11:0] hwx, hwy, vwx, vwy;
    logic        col_valid, col_ready;
    logic [5:0]  col_index;
    logic [12:0] col_dist;
    logic        col_hit, col_side, busy, frame_done;

    ray_column_scheduler #(
        .NUM_COLS(NUM_COLS), .HALF_FOV(HALF_FOV),
        .ANGLE_STEP(STEP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock_i(clock), .reset_i(reset), .frame_start_i(frame_start),
        .player_x_i(player_x), .player_y_i(player_y), .player_angle_i(player_angle),
        .ray_x_o(ray_x), .ray_y_o(ray_y), .ray_alpha_o(ray_alpha),
        .horiz_begin_o(horiz_begin), .vert_begin_o(vert_begin),
        .horiz_end_i(horiz_end), .vert_end_i(vert_end),
        .horiz_found_i(horiz_found), .vert_found_i(vert_found),
        .horiz_wall_x_i(hwx), .horiz_wall_y_i(hwy),
        .vert_wall_x_i(vwx), .vert_wall_y_i(vwy),
        .col_valid_o(col_valid), .col_ready_i(col_ready),
        .col_index_o(col_index), .col_dist_o(col_dist),
        .col_hit_o(col_hit), .col_side_o(col_side),
        .busy_o(busy), .frame_done_o(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks;
    int n_errors;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-column scenario: finder end delays (0 = never), results, stalls.
    int hd[NUM_COLS], vd[NUM_COLS];
    bit hf[NUM_COLS], vf[NUM_COLS];
    int hx[NUM_COLS], hy[NUM_COLS], vx[NUM_COLS], vy[NUM_COLS];
    int stall[NUM_COLS];
    bit stale[NUM_COLS], dupe[NUM_COLS];

    // Model: wait length, launch time of each column, expected record.
    int W[NUM_COLS];
    int L[NUM_COLS+1];
    int e_dist[NUM_COLS], e_hit[NUM_COLS], e_side[NUM_COLS];
    int cap_dist[NUM_COLS], cap_hit[NUM_COLS], cap_side[NUM_COLS], cap_alpha[NUM_COLS];
    int rx, ry, a0;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // An end pulse d cycles after launch lands in wait cycle d-1.
    function automatic bit seen(input int d);
        return (d >= 1) && (d <= TMO);
    endfunction

    function automatic int exp_alpha(input int c);
        return ((a0 - c * STEP) % 360 + 360) % 360;
    endfunction

    task automatic build_model();
        L[0] = 1;
        for (int c = 0; c < NUM_COLS; c++) begin
            bit hc, vc, hh, vh;
            int dh, dv;
            hc = seen(hd[c]);
            vc = seen(vd[c]);
            W[c] = (hc && vc) ? ((hd[c] > vd[c]) ? hd[c] : vd[c]) : TMO;
            hh = hc && hf[c];
            vh = vc && vf[c];
            dh = absd(hx[c], rx) + absd(hy[c], ry);
            dv = absd(vx[c], rx) + absd(vy[c], ry);
            if (hh && vh) begin
                e_hit[c] = 1;
                if (dv < dh) begin e_dist[c] = dv; e_side[c] = 1; end
                else         begin e_dist[c] = dh; e_side[c] = 0; end
            end else if (hh) begin
                e_hit[c] = 1; e_dist[c] = dh; e_side[c] = 0;
            end else if (vh) begin
                e_hit[c] = 1; e_dist[c] = dv; e_side[c] = 1;
            end else begin
                e_hit[c] = 0; e_dist[c] = 8191; e_side[c] = 0;
            end
            L[c+1] = L[c] + W[c] + 3 + stall[c];
            cap_dist[c] = -1; cap_hit[c] = -1; cap_side[c] = -1; cap_alpha[c] = -1;
        end
    endtask

    task automatic cfg_random();
        for (int c = 0; c < NUM_COLS; c++) begin
            hd[c] = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 12));
            vd[c] = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 12));
            hf[c] = ($urandom_range(0, 3) != 0);
            vf[c] = ($urandom_range(0, 3) != 0);
            hx[c] = $urandom_range(0, 4095); hy[c] = $urandom_range(0, 4095);
            vx[c] = $urandom_range(0, 4095); vy[c] = $urandom_range(0, 4095);
            stall[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            stale[c] = ($urandom_range(0, 3) == 0);
            dupe[c]  = ($urandom_range(0, 2) == 0);
        end
    endtask

    // Runs one frame starting at the current negedge. abort_col >= 0 pulses
    // reset during that column's wait; spur_t injects a frame_start mid-frame;
    // done_start injects a frame_start in the frame_done cycle.
    task automatic run_frame(input int px, input int py, input int ang,
                             input int abort_col, input int spur_t, input bit done_start);
        int  c, lend;
        bit  aborted;
        rx = px; ry = py; a0 = (ang + HALF_FOV) % 360;
        build_model();
        lend = L[NUM_COLS];
        player_x = 12'(px); player_y = 12'(py); player_angle = 12'(ang);
        frame_start = 1'b1;
        c = 0;
        aborted = 1'b0;
        for (int t = 1; t <= lend + 2; t++) begin
            bit in_frame, h_real, h_dup, h_stale, v_real, v_dup;
            int o;
            string tag;
            @(negedge clock);
            frame_start  = 1'b0;
            player_x     = 12'($urandom_range(0, 4095));
            player_y     = 12'($urandom_range(0, 4095));
            player_angle = 12'($urandom_range(0, 359));
            while (c < NUM_COLS - 1 && t >= L[c+1]) c++;
            in_frame = (t < lend);
            o = t - L[c];
            tag = $sformatf("c%0d_t%0d", c, t);

            check({tag, "_hbegin"}, int'(horiz_begin), int'(in_frame && o == 0));
            check({tag, "_vbegin"}, int'(vert_begin),  int'(in_frame && o == 0));
            check({tag, "_valid"},  int'(col_valid),   int'(in_frame && o >= W[c] + 2));
            check({tag, "_done"},   int'(frame_done),  int'(t == lend));
            check({tag, "_busy"},   int'(busy),        int'(t <= lend));
            if (t <= lend) begin
                check({tag, "_rayx"}, int'(ray_x), rx);
                check({tag, "_rayy"}, int'(ray_y), ry);
            end
            if (in_frame && o <= W[c] + 1)
                check({tag, "_alpha"}, int'(ray_alpha), exp_alpha(c));
            if (in_frame && o == 0) cap_alpha[c] = int'(ray_alpha);
            if (in_frame && o >= W[c] + 2) begin
                check({tag, "_index"}, int'(col_index), c);
                check({tag, "_dist"},  int'(col_dist),  e_dist[c]);
                check({tag, "_hit"},   int'(col_hit),   e_hit[c]);
                check({tag, "_side"},  int'(col_side),  e_side[c]);
                if (o == W[c] + 2) begin
                    cap_dist[c] = int'(col_dist);
                    cap_hit[c]  = int'(col_hit);
                    cap_side[c] = int'(col_side);
                end
            end

            if (abort_col == c && in_frame && o == 2) begin
                reset = 1'b1;
                horiz_end = 1'b0; vert_end = 1'b0;
                aborted = 1'b1;
                break;
            end

            h_real  = in_frame && hd[c] > 0 && o == hd[c] && o <= W[c];
            h_dup   = in_frame && dupe[c] && hd[c] > 0 && o == hd[c] + 1 && o <= W[c];
            h_stale = in_frame && stale[c] && o == 0;
            v_real  = in_frame && vd[c] > 0 && o == vd[c] && o <= W[c];
            v_dup   = in_frame && dupe[c] && vd[c] > 0 && o == vd[c] + 1 && o <= W[c];
            horiz_end = h_real || h_dup || h_stale;
            vert_end  = v_real || v_dup || h_stale;
            if (h_real) begin
                horiz_found = hf[c]; hwx = 12'(hx[c]); hwy = 12'(hy[c]);
            end else begin
                horiz_found = 1'($urandom_range(0, 1));
                hwx = 12'($urandom_range(0, 4095)); hwy = 12'($urandom_range(0, 4095));
            end
            if (v_real) begin
                vert_found = vf[c]; vwx = 12'(vx[c]); vwy = 12'(vy[c]);
            end else begin
                vert_found = 1'($urandom_range(0, 1));
                vwx = 12'($urandom_range(0, 4095)); vwy = 12'($urandom_range(0, 4095));
            end
            if (in_frame && o >= W[c] + 2) col_ready = (o == W[c] + 2 + stall[c]);
            else                           col_ready = 1'($urandom_range(0, 1));
            if (t == spur_t)                frame_start = 1'b1;
            if (done_start && t == lend)    frame_start = 1'b1;
        end
        horiz_end = 1'b0; vert_end = 1'b0; frame_start = 1'b0;
        if (aborted) begin
            @(negedge clock);
            reset = 1'b0;
            check("abort_busy",  int'(busy),       0);
            check("abort_valid", int'(col_valid),  0);
            check("abort_done",  int'(frame_done), 0);
            check("abort_dist",  int'(col_dist),   8191);
            check("abort_alpha", int'(ray_alpha),  0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clock);
                check($sformatf("abort_begin_%0d", k), int'(horiz_begin | vert_begin), 0);
                check($sformatf("abort_idle_%0d", k),  int'(busy), 0);
            end
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1'b1; frame_start = 1'b0;
        player_x = '0; player_y = '0; player_angle = '0;
        horiz_end = 1'b0; vert_end = 1'b0; horiz_found = 1'b0; vert_found = 1'b0;
        hwx = '0; hwy = '0; vwx = '0; vwy = '0; col_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_busy",  int'(busy),        0);
        check("rst_valid", int'(col_valid),   0);
        check("rst_dist",  int'(col_dist),    8191);
        check("rst_hit",   int'(col_hit),     0);
        check("rst_index", int'(col_index),   0);
        check("rst_alpha", int'(ray_alpha),   0);
        check("rst_begin", int'(horiz_begin | vert_begin), 0);
        check("rst_done",  int'(frame_done),  0);
        reset = 1'b0;
        @(negedge clock);

        // Frame A: basic hit selection on column 0.
        cfg_random();
        hd[0] = 5; hf[0] = 1; hx[0] = 100; hy[0] = 63;
        vd[0] = 8; vf[0] = 0; stall[0] = 0;
        run_frame(100, 200, 90, -1, -1, 1'b0);
        check("A_c0_dist", cap_dist[0], 137);
        check("A_c0_hit",  cap_hit[0],  1);
        check("A_c0_side", cap_side[0], 0);

        // Frame B: angle wrap, tie, vertical win, simultaneous ends,
        // timeouts, long backpressure and an ignored mid-frame start.
        cfg_random();
        hd[1] = 3; vd[1] = 6; hf[1] = 1; vf[1] = 1;
        hx[1] = 1030; hy[1] = 2020; vx[1] = 980;  vy[1] = 1970;
        hd[2] = 2; vd[2] = 7; hf[2] = 1; vf[2] = 1;
        hx[2] = 1080; hy[2] = 2000; vx[2] = 1000; vy[2] = 2030;
        hd[3] = 4; vd[3] = 4; hf[3] = 1; vf[3] = 1;
        hx[3] = 1000; hy[3] = 2100; vx[3] = 1000; vy[3] = 1950;
        hd[4] = 3; vd[4] = 0; hf[4] = 1; hx[4] = 1005; hy[4] = 2007;
        hd[5] = 0; vd[5] = 0;
        hd[6] = 2; vd[6] = 3; stall[6] = 20;
        run_frame(1000, 2000, 10, -1, 150, 1'b0);
        check("B_alpha_c0",  cap_alpha[0],  40);
        check("B_alpha_c40", cap_alpha[40], 0);
        check("B_alpha_c41", cap_alpha[41], 359);
        check("B_alpha_c59", cap_alpha[59], 341);
        check("B_tie_dist",  cap_dist[1], 50);
        check("B_tie_side",  cap_side[1], 0);
        check("B_vwin_dist", cap_dist[2], 30);
        check("B_vwin_side", cap_side[2], 1);
        check("B_same_dist", cap_dist[3], 50);
        check("B_same_side", cap_side[3], 1);
        check("B_tmo1_hit",  cap_hit[4],  1);
        check("B_tmo1_dist", cap_dist[4], 12);
        check("B_tmo1_side", cap_side[4], 0);
        check("B_tmo2_hit",  cap_hit[5],  0);
        check("B_tmo2_dist", cap_dist[5], 8191);

        // Frame C: wrap on start angle, reset during column 7's wait.
        cfg_random();
        hd[7] = 5; vd[7] = 6;
        run_frame(3000, 50, 350, 7, -1, 1'b0);
        check("C_alpha_c0", cap_alpha[0], 20);

        // Frame D: restart from column 0 after abort; start during done ignored.
        cfg_random();
        run_frame($urandom_range(0, 4095), $urandom_range(0, 4095),
                  $urandom_range(0, 359), -1, 40, 1'b1);

        // Frame E: another random frame.
        cfg_random();
        run_frame($urandom_range(0, 4095), $urandom_range(0, 4095),
                  $urandom_range(0, 359), -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
